// File: rtl/branch_resolve_unit.sv
// Branch resolution for BEQ/BNE in the ID stage of a 5-stage MIPS pipeline.
// The unit consumes the ID-stage register-equality flag and holds the front
// end while a branch operand is still being produced in EX or MEM. It then
// drives the PC-source select and the IF/ID flush.
// Three saturating counters track resolved branches, taken branches and
// branch-induced stall cycles.
module branch_resolve_unit #(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_beq,
    input  logic             id_bne,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             cmp_equal,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             kill,
    output logic             stall,
    output logic             pc_src,
    output logic             if_flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // A register matches when it is not $0 and names either branch source.
    function automatic logic reg_match(input logic [REG_W-1:0] r,
                                       input logic [REG_W-1:0] rs,
                                       input logic [REG_W-1:0] rt);
        return (r != {REG_W{1'b0}}) && ((r == rs) || (r == rt));
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return v;
        end
    endfunction

    state_t           state_q, state_d;
    logic             wc_q, wc_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       br_s;
    logic       taken_s;
    logic [1:0] need_s;
    logic       stall_s;
    logic       pc_src_s;
    logic       resolve_s;

    // Branch presence, direction and hazard depth (stall cycles required).
    // BEQ and BNE asserted together resolve as BEQ.
    always_comb begin
        br_s    = id_beq | id_bne;
        taken_s = id_beq ? cmp_equal : ~cmp_equal;
        need_s  = 2'd0;
        if (ex_mem_read && reg_match(ex_rd, id_rs, id_rt)) begin
            need_s = 2'd2;
        end else if ((ex_reg_write && !ex_mem_read && reg_match(ex_rd, id_rs, id_rt)) ||
                     (mem_mem_read && reg_match(mem_rd, id_rs, id_rt))) begin
            need_s = 2'd1;
        end else begin
            need_s = 2'd0;
        end
    end

    // Next-state and output decode. Kill and reset both drop the branch.
    always_comb begin
        state_d   = state_q;
        wc_d      = wc_q;
        stall_s   = 1'b0;
        pc_src_s  = 1'b0;
        resolve_s = 1'b0;
        if (!rst_n) begin
            state_d = ST_RUN;
            wc_d    = 1'b0;
        end else if (kill) begin
            state_d = ST_RUN;
            wc_d    = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!br_s) begin
                        state_d = ST_RUN;
                    end else if (need_s == 2'd0) begin
                        resolve_s = 1'b1;
                        pc_src_s  = taken_s;
                    end else begin
                        stall_s = 1'b1;
                        wc_d    = (need_s == 2'd2);
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Hazard inputs are deliberately ignored here; the
                    // stall depth was fixed when the branch entered WAIT.
                    if (wc_q) begin
                        stall_s = 1'b1;
                        wc_d    = 1'b0;
                    end else begin
                        resolve_s = 1'b1;
                        pc_src_s  = taken_s;
                        state_d   = ST_RUN;
                        wc_d      = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    wc_d    = 1'b0;
                end
            endcase
        end
    end

    // Counter next values; reset and kill suppress all updates.
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (!rst_n) begin
            branch_cnt_d = {CNT_W{1'b0}};
            taken_cnt_d  = {CNT_W{1'b0}};
            stall_cnt_d  = {CNT_W{1'b0}};
        end else begin
            branch_cnt_d = sat_inc(branch_cnt_q, resolve_s);
            taken_cnt_d  = sat_inc(taken_cnt_q, resolve_s & pc_src_s);
            stall_cnt_d  = sat_inc(stall_cnt_q, stall_s);
        end
    end

    // State, wait counter and performance counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            wc_q         <= 1'b0;
            branch_cnt_q <= {CNT_W{1'b0}};
            taken_cnt_q  <= {CNT_W{1'b0}};
            stall_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            wc_q         <= wc_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign stall      = stall_s;
    assign pc_src     = pc_src_s;
    assign if_flush   = pc_src_s;
    assign branch_cnt = branch_cnt_q;
    assign taken_cnt  = taken_cnt_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a default-width instance and a
// 2-bit-counter instance share the same stimulus.
module tb_branch_resolve_unit;

    logic       clk = 1'b0;
    logic       rst_n, id_beq, id_bne, cmp_equal, ex_reg_write, ex_mem_read;
    logic       mem_mem_read, kill;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;

    logic        stall, pc_src, if_flush;
    logic [15:0] branch_cnt, taken_cnt, stall_cnt;
    logic        s_stall, s_pc_src, s_if_flush;
    logic [1:0]  s_branch_cnt, s_taken_cnt, s_stall_cnt;

    typedef struct {
        string tag;
        logic  stall;
        logic  pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   eb = 0;
    int   et = 0;
    int   es = 0;

    branch_resolve_unit #(.CNT_W(16), .REG_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_beq(id_beq), .id_bne(id_bne),
        .id_rs(id_rs), .id_rt(id_rt), .cmp_equal(cmp_equal),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .kill(kill),
        .stall(stall), .pc_src(pc_src), .if_flush(if_flush),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
    );

    branch_resolve_unit #(.CNT_W(2), .REG_W(5)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_beq(id_beq), .id_bne(id_bne),
        .id_rs(id_rs), .id_rt(id_rt), .cmp_equal(cmp_equal),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .kill(kill),
        .stall(s_stall), .pc_src(s_pc_src), .if_flush(s_if_flush),
        .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt), .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    // Count a comparison and report any mismatch.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare them
    // mid-cycle, then advance past the next rising edge.
    task automatic step(input string tag, input logic rn, input logic beq, input logic bne,
                        input logic [4:0] rs, input logic [4:0] rt, input logic eq,
                        input logic exrw, input logic exmr, input logic [4:0] exrd,
                        input logic mmr, input logic [4:0] mrd, input logic kl,
                        input logic e_stall, input logic e_pc);
        exp_t e;
        rst_n = rn; id_beq = beq; id_bne = bne; id_rs = rs; id_rt = rt;
        cmp_equal = eq; ex_reg_write = exrw; ex_mem_read = exmr; ex_rd = exrd;
        mem_mem_read = mmr; mem_rd = mrd; kill = kl;
        exp_q.push_back('{tag, e_stall, e_pc});
        #3;
        e = exp_q.pop_front();
        chk({e.tag, "_stall"}, 32'(stall), 32'(e.stall));
        chk({e.tag, "_pc_src"}, 32'(pc_src), 32'(e.pc));
        chk({e.tag, "_if_flush"}, 32'(if_flush), 32'(e.pc));
        @(posedge clk);
        #1;
    endtask

    // Compare the full-width counters with the bench's running totals.
    task automatic chk_cnt(input string tag);
        chk({tag, "_branch_cnt"}, 32'(branch_cnt), 32'(eb));
        chk({tag, "_taken_cnt"}, 32'(taken_cnt), 32'(et));
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(es));
    endtask

    // Directed scenario script.
    initial begin
        rst_n = 1'b0; id_beq = 1'b0; id_bne = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
        cmp_equal = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
        mem_mem_read = 1'b0; mem_rd = 5'd0; kill = 1'b0;
        @(posedge clk);
        #1;

        // reset held two cycles with a taken-looking BEQ present
        step("rst0", 1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("rst1", 1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_cnt("after_rst");

        // no hazard: BEQ taken, then BNE not taken
        step("beq_nohz", 1'b1, 1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
        eb = 1; et = 1; chk_cnt("beq_nohz");
        step("bne_nohz", 1'b1, 1'b0, 1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
        eb = 2; chk_cnt("bne_nohz");

        // ALU hazard: one stall then not-taken BEQ
        step("alu_s", 1'b1, 1'b1, 1'b0, 5'd5, 5'd4, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("alu_r", 1'b1, 1'b1, 1'b0, 5'd5, 5'd4, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        eb = 3; es = 1; chk_cnt("alu");

        // load in EX: two stalls, BNE with unequal operands is taken
        step("ld_s1", 1'b1, 1'b0, 1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("ld_s2", 1'b1, 1'b0, 1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0);
        step("ld_r", 1'b1, 1'b0, 1'b1, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        eb = 4; et = 2; es = 3; chk_cnt("ld_ex");

        // load in MEM: one stall
        step("mld_s", 1'b1, 1'b0, 1'b1, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0);
        step("mld_r", 1'b1, 1'b0, 1'b1, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        eb = 5; et = 3; es = 4; chk_cnt("ld_mem");

        // $0 never hazards
        step("zero", 1'b1, 1'b1, 1'b0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        eb = 6; et = 4; chk_cnt("zero");

        // load hazard abandoned by kill in WAIT, then idle in RUN
        step("kill_s", 1'b1, 1'b1, 1'b0, 5'd5, 5'd4, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("kill_k", 1'b1, 1'b1, 1'b0, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step("kill_idle", 1'b1, 1'b0, 1'b0, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        es = 5; chk_cnt("kill");

        // BEQ and BNE together resolve as BEQ
        step("both", 1'b1, 1'b1, 1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        eb = 7; et = 5; chk_cnt("both");

        // a new hazard seen while in WAIT does not extend the stall
        step("ign_s", 1'b1, 1'b1, 1'b0, 5'd5, 5'd4, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("ign_r", 1'b1, 1'b1, 1'b0, 5'd5, 5'd4, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        eb = 8; et = 6; es = 6; chk_cnt("ign");

        // 2-bit counters are saturated at 3 by now
        chk("sat_branch_mid", 32'(s_branch_cnt), 32'd3);
        chk("sat_taken_mid", 32'(s_taken_cnt), 32'd3);
        chk("sat_stall_mid", 32'(s_stall_cnt), 32'd3);

        // reset mid-WAIT drops the branch and clears the counters
        step("rw_s", 1'b1, 1'b1, 1'b0, 5'd5, 5'd4, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("rw_rst", 1'b0, 1'b1, 1'b0, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("rw_idle", 1'b1, 1'b0, 1'b0, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        eb = 0; et = 0; es = 0; chk_cnt("rst_wait");

        // five taken branches: full-width counts 5, 2-bit counts stick at 3
        for (int i = 0; i < 5; i++) begin
            step("sat", 1'b1, 1'b1, 1'b0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        end
        eb = 5; et = 5; chk_cnt("sat_full");
        chk("sat_branch_cnt", 32'(s_branch_cnt), 32'd3);
        chk("sat_taken_cnt", 32'(s_taken_cnt), 32'd3);
        chk("sat_stall_cnt", 32'(s_stall_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Consumer end of the ID-stage register-equality comparator in the 5-stage pipelined MIPS. Takes the comparator's equal flag for BEQ/BNE in ID and decides the branch direction. Stalls the front end while branch operands are still in flight from EX/MEM, then drives PC-source select and the IF/ID flush. Keeps saturating performance counters for branches, taken branches and branch-induced stall cycles.

Parameters:
CNT_W, 16, width of each performance counter
REG_W, 5, register-specifier width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  synchronous active-low reset
id_beq  in  1  ID holds a BEQ
id_bne  in  1  ID holds a BNE
id_rs  in  REG_W  branch source register rs
id_rt  in  REG_W  branch source register rt
cmp_equal  in  1  comparator result, 1 = operands equal
ex_reg_write  in  1  EX instruction writes a register
ex_mem_read  in  1  EX instruction is a load
ex_rd  in  REG_W  EX destination register
mem_mem_read  in  1  MEM instruction is a load
mem_rd  in  REG_W  MEM destination register
kill  in  1  discard the branch in ID (higher-priority flush)
stall  out  1  freeze PC and IF/ID, insert bubble into ID/EX
pc_src  out  1  1 = select branch target this cycle
if_flush  out  1  flush IF/ID; equals pc_src
branch_cnt  out  CNT_W  branches resolved
taken_cnt  out  CNT_W  branches taken
stall_cnt  out  CNT_W  cycles with stall=1

Behaviour:
- br = id_beq | id_bne. id_beq & id_bne together is illegal. Treat it as BEQ.
- Match(r) = (r != 0) & (r == id_rs | r == id_rt). Register $0 never causes a hazard.
- need = 2 if ex_mem_read & Match(ex_rd).
- Otherwise need = 1 if (ex_reg_write & ~ex_mem_read & Match(ex_rd)) | (mem_mem_read & Match(mem_rd)).
- Otherwise need = 0.
- State machine has two states, RUN and WAIT, plus a 1-bit wait counter wc.
- RUN, br=0: stall=0, pc_src=0, stay in RUN.
- RUN, br=1, need=0: resolve in the same cycle with stall=0. taken = id_beq ? cmp_equal : ~cmp_equal. pc_src=taken. Stay in RUN.
- RUN, br=1, need>0: stall=1, pc_src=0, wc<=need-1, go to WAIT.
- WAIT, wc=1: stall=1, wc<=0, stay in WAIT.
- WAIT, wc=0: stall=0, resolve as above using the current cmp_equal, return to RUN.
- Total stall latency is need cycles. Resolution happens on the cycle after the last stall.
- Hazard inputs are ignored while in WAIT. The decision made in RUN is final.
- pc_src, if_flush and stall are combinational from state and inputs. They are 0 whenever rst_n=0.
- kill=1 forces stall=0 and pc_src=0 and sends the FSM to RUN with wc=0. No counter updates that cycle. kill has priority over everything except reset.
- Counters update on the clock edge, each saturating at 2^CNT_W-1 with no wrap:
  - branch_cnt +1 on every resolve cycle.
  - taken_cnt +1 on every resolve cycle with pc_src=1.
  - stall_cnt +1 on every cycle with stall=1.
- Reset (rst_n=0 at a rising edge): state=RUN, wc=0, all counters=0. Reset mid-WAIT abandons the branch. No resolve occurs for it.

Test Plan:
- Reset: rst_n=0 for 2 cycles with id_beq=1, cmp_equal=1 -> stall=0, pc_src=0, all counters 0 after release.
- No hazard: BEQ rs=3 rt=4, cmp_equal=1, no matching EX/MEM -> pc_src=1, if_flush=1, stall=0 same cycle. branch_cnt=1, taken_cnt=1. Repeat as BNE -> pc_src=0, taken_cnt unchanged.
- ALU hazard: BEQ rs=5, ex_reg_write=1, ex_rd=5, cmp_equal=0 -> stall=1 for 1 cycle, then pc_src=0. stall_cnt=1, branch_cnt=1.
- Load hazard: BNE rt=7, ex_mem_read=1, ex_rd=7 -> stall=1 for 2 cycles. Third cycle with cmp_equal=0 -> pc_src=1. stall_cnt=2. Same branch with mem_mem_read=1, mem_rd=7 instead -> 1 stall.
- $0 and kill: ex_mem_read=1, ex_rd=0, rs=0 -> no stall. Load hazard then kill=1 in WAIT -> stall drops that cycle, no pc_src, branch_cnt unchanged.
- Saturation with CNT_W=2: 5 taken no-hazard branches -> branch_cnt=3, taken_cnt=3, no wrap.
